// File: rtl/ascii_text_pkg.sv
// Shared state encoding, control-code constants and default screen geometry
// for the ASCII text buffer writer.
package ascii_text_pkg;

    typedef enum logic [1:0] {
        CLR_ALL = 2'd0,
        IDLE    = 2'd1,
        CLR_ROW = 2'd2
    } state_e;

    localparam logic [7:0] ASCII_BS       = 8'h08;
    localparam logic [7:0] ASCII_LF       = 8'h0A;
    localparam logic [7:0] ASCII_FF       = 8'h0C;
    localparam logic [7:0] ASCII_CR       = 8'h0D;
    localparam logic [7:0] ASCII_PRINT_LO = 8'h20;
    localparam logic [7:0] ASCII_PRINT_HI = 8'h7E;

    localparam int DEF_COLS = 80;
    localparam int DEF_ROWS = 30;

endpackage

// File: rtl/ascii_text_buffer_writer_text_cursor.sv
// Terminal cursor: column/row registers with advance, newline, carriage return,
// backspace and home operations; flags when an operation wraps past the last row.
module text_cursor
    import ascii_text_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       adv_i,
    input  logic       lf_i,
    input  logic       cr_i,
    input  logic       bs_i,
    input  logic       home_i,
    output logic [6:0] col_o,
    output logic [4:0] row_o,
    output logic       wrap_row_o
);

    logic [6:0] col_q, col_d;
    logic [4:0] row_q, row_d;
    logic       last_col;
    logic       last_row;

    assign last_col   = (col_q == 7'(COLS - 1));
    assign last_row   = (row_q == 5'(ROWS - 1));
    assign wrap_row_o = last_row && (lf_i || (adv_i && last_col));
    assign col_o      = col_q;
    assign row_o      = row_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (home_i) begin
            col_d = '0;
            row_d = '0;
        end else if (adv_i && !last_col) begin
            col_d = col_q + 7'd1;
        end else if (adv_i || lf_i) begin
            // Column wrap and LF share the newline path; no scrolling, row 0 follows the last row.
            col_d = '0;
            row_d = last_row ? '0 : row_q + 5'd1;
        end else if (cr_i) begin
            col_d = '0;
        end else if (bs_i && (col_q != 7'd0)) begin
            col_d = col_q - 7'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/ascii_text_buffer_writer.sv
// Consumes an ASCII valid/ready stream, interprets it as terminal text and
// drives the write port of the COLS x ROWS character frame buffer.
module ascii_text_buffer_writer
    import ascii_text_pkg::*;
#(
    parameter int         COLS      = DEF_COLS,
    parameter int         ROWS      = DEF_ROWS,
    parameter int         ADDR_W    = 12,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        ascii_in,
    input  logic              ascii_valid,
    output logic              ascii_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [6:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic [11:0]       char_count,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic [11:0]       cnt_q, cnt_d;

    logic              accept, is_print, is_lf, is_cr, is_bs, is_ff;
    logic              clr_done, wrap_row;
    logic [ADDR_W-1:0] row_base, cur_addr;

    // ready_q is only ever high in IDLE, so it alone qualifies the handshake.
    assign accept   = ascii_valid && ready_q;
    assign is_print = accept && (ascii_in >= ASCII_PRINT_LO) && (ascii_in <= ASCII_PRINT_HI);
    assign is_lf    = accept && (ascii_in == ASCII_LF);
    assign is_cr    = accept && (ascii_in == ASCII_CR);
    assign is_bs    = accept && (ascii_in == ASCII_BS) && (cursor_col != 7'd0);
    assign is_ff    = accept && (ascii_in == ASCII_FF);
    assign clr_done = (state_q == CLR_ALL) && (ptr_q == LAST_CELL);
    assign row_base = ADDR_W'(cursor_row) * COLS_A;
    assign cur_addr = row_base + ADDR_W'(cursor_col);

    text_cursor #(
        .COLS(COLS),
        .ROWS(ROWS)
    ) u_cursor (
        .clk       (clk),
        .reset     (reset),
        .adv_i     (is_print),
        .lf_i      (is_lf),
        .cr_i      (is_cr),
        .bs_i      (is_bs),
        .home_i    (clr_done),
        .col_o     (cursor_col),
        .row_o     (cursor_row),
        .wrap_row_o(wrap_row)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        cnt_d     = cnt_q;
        case (state_q)
            CLR_ALL: begin
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = FILL_CHAR;
                ptr_d     = ptr_q + ADDR_W'(1);
                if (ptr_q == LAST_CELL) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                    cnt_d   = '0;
                end
            end
            CLR_ROW: begin
                wr_en_d   = 1'b1;
                wr_addr_d = row_base + ptr_q;
                wr_data_d = FILL_CHAR;
                ptr_d     = ptr_q + ADDR_W'(1);
                if (ptr_q == LAST_COL) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end
            end
            IDLE: begin
                if (is_print) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cur_addr;
                    wr_data_d = ascii_in;
                    if (cnt_q != 12'hFFF) cnt_d = cnt_q + 12'd1;
                    if (wrap_row) state_d = CLR_ROW;
                end else if (is_lf) begin
                    if (wrap_row) state_d = CLR_ROW;
                end else if (is_bs) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cur_addr - ADDR_W'(1);
                    wr_data_d = FILL_CHAR;
                end else if (is_ff) begin
                    state_d = CLR_ALL;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = CLR_ALL;
                ptr_d   = '0;
            end
        endcase
        // Hold ready low for the cycle that still shows the final clear write.
        ready_d = (state_q == IDLE) && (state_d == IDLE);
        busy_d  = (state_q != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= CLR_ALL;
            ptr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= FILL_CHAR;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ascii_ready = ready_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign char_count  = cnt_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ascii_text_buffer_writer.sv
// Directed bench for ascii_text_buffer_writer: a screen-level model predicts every
// frame buffer write and the cursor/count, checked on each negative clock edge.
module tb_ascii_text_buffer_writer;

    localparam int         COLS  = 80;
    localparam int         ROWS  = 30;
    localparam int         CELLS = COLS * ROWS;
    localparam logic [7:0] FILL  = 8'h20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  ascii_in = 8'h00;
    logic        ascii_valid = 1'b0;
    logic        ascii_ready, wr_en, busy;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic [11:0] char_count;

    int vectors = 0;
    int errors  = 0;

    int exp_addr_q[$];
    int exp_data_q[$];
    int m_col = 0;
    int m_row = 0;
    int m_cnt = 0;

    ascii_text_buffer_writer #(
        .COLS(COLS), .ROWS(ROWS), .ADDR_W(12), .FILL_CHAR(FILL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ascii_in   (ascii_in),
        .ascii_valid(ascii_valid),
        .ascii_ready(ascii_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .char_count (char_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic void push_fill(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(base + i);
            exp_data_q.push_back(int'(FILL));
        end
    endfunction

    function automatic void model_reset();
        exp_addr_q.delete();
        exp_data_q.delete();
        m_col = 0;
        m_row = 0;
        m_cnt = 0;
        push_fill(0, CELLS);
    endfunction

    // Terminal semantics of one accepted character; returns 1 when the character
    // itself writes a cell (which must appear on the port the following cycle).
    function automatic bit model_accept(input logic [7:0] c);
        bit imm = 1'b0;
        if (c >= 8'h20 && c <= 8'h7E) begin
            exp_addr_q.push_back(m_row * COLS + m_col);
            exp_data_q.push_back(int'(c));
            if (m_cnt < 4095) m_cnt++;
            imm = 1'b1;
            m_col++;
            if (m_col == COLS) begin
                m_col = 0;
                m_row++;
            end
        end else if (c == 8'h0A) begin
            m_col = 0;
            m_row++;
        end else if (c == 8'h0D) begin
            m_col = 0;
        end else if (c == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                exp_addr_q.push_back(m_row * COLS + m_col);
                exp_data_q.push_back(int'(FILL));
                imm = 1'b1;
            end
        end else if (c == 8'h0C) begin
            push_fill(0, CELLS);
            m_col = 0;
            m_row = 0;
            m_cnt = 0;
        end
        if (m_row == ROWS) begin
            m_row = 0;
            push_fill(0, COLS);
        end
        return imm;
    endfunction

    // Compare process: every write against the predicted stream, cursor/count whenever idle.
    initial begin
        int a;
        int d;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (wr_en === 1'b1) begin
                    if (exp_addr_q.size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL wr_unexpected: write addr %0d data 0x%0h, none expected", wr_addr, wr_data);
                    end else begin
                        a = exp_addr_q.pop_front();
                        d = exp_data_q.pop_front();
                        check("wr_addr", 32'(wr_addr), a);
                        check("wr_data", 32'(wr_data), d);
                    end
                end
                if (ascii_ready === 1'b1) begin
                    check("cursor_col", 32'(cursor_col), m_col);
                    check("cursor_row", 32'(cursor_row), m_row);
                    check("char_count", 32'(char_count), m_cnt);
                    check("busy_when_ready", 32'(busy), 0);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [7:0] c, output int busy_cycles);
        int guard;
        bit imm;
        guard = 0;
        busy_cycles = 0;
        ascii_in = c;
        ascii_valid = 1'b1;
        while (ascii_ready !== 1'b1 && guard < 5000) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) begin
            vectors++;
            errors++;
            $display("FAIL send_timeout: char 0x%0h not accepted within %0d cycles", c, guard);
            ascii_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        imm = model_accept(c);
        @(negedge clk);
        ascii_valid = 1'b0;
        check("wr_en_after_accept", 32'(wr_en), 32'(imm));
    endtask

    task automatic wait_idle(output int busy_cycles);
        int guard;
        guard = 0;
        busy_cycles = 0;
        @(negedge clk);
        while (ascii_ready !== 1'b1 && guard < 5000) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) begin
            vectors++;
            errors++;
            $display("FAIL idle_timeout: ready not seen within %0d cycles", guard);
        end
    endtask

    initial begin
        int nb;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 32'h20);
        check("rst_col", 32'(cursor_col), 0);
        check("rst_row", 32'(cursor_row), 0);
        check("rst_count", 32'(char_count), 0);
        check("rst_ready", 32'(ascii_ready), 0);
        check("rst_busy", 32'(busy), 1);
        reset = 1'b0;
        wait_idle(nb);
        check("init_clear_cycles", nb, 2400);

        // "AB" back-to-back
        send(8'h41, nb);
        check("A_addr", 32'(wr_addr), 0);
        check("A_data", 32'(wr_data), 32'h41);
        send(8'h42, nb);
        check("B_addr", 32'(wr_addr), 1);
        check("B_data", 32'(wr_data), 32'h42);
        check("AB_col", 32'(cursor_col), 2);
        check("AB_count", 32'(char_count), 2);

        // Column wrap from col 79, then LF/CR
        for (int i = 0; i < 77; i++) send(8'h78, nb);
        check("col79", 32'(cursor_col), 79);
        send(8'h5A, nb);
        check("Z_addr", 32'(wr_addr), 79);
        check("Z_data", 32'(wr_data), 32'h5A);
        check("Z_col", 32'(cursor_col), 0);
        check("Z_row", 32'(cursor_row), 1);
        send(8'h0A, nb);
        send(8'h0D, nb);
        check("lfcr_col", 32'(cursor_col), 0);
        check("lfcr_row", 32'(cursor_row), 2);

        // Backspace at (5,3) and at col 0
        send(8'h0A, nb);
        for (int i = 0; i < 5; i++) send(8'h31 + 8'(i), nb);
        send(8'h08, nb);
        check("bs_addr", 32'(wr_addr), 244);
        check("bs_data", 32'(wr_data), 32'h20);
        check("bs_col", 32'(cursor_col), 4);
        check("bs_count", 32'(char_count), 85);
        send(8'h0D, nb);
        send(8'h08, nb);
        check("bs0_col", 32'(cursor_col), 0);

        // LF at row 29 clears row 0; held character waits for ready
        for (int i = 0; i < 26; i++) send(8'h0A, nb);
        check("row29", 32'(cursor_row), 29);
        send(8'h0A, nb);
        check("lfwrap_col", 32'(cursor_col), 0);
        check("lfwrap_row", 32'(cursor_row), 0);
        send(8'h51, nb);
        check("rowclr_cycles", nb, 80);
        check("Q_addr", 32'(wr_addr), 0);
        check("Q_data", 32'(wr_data), 32'h51);

        // Printable at (79,29) wraps to row 0 and clears it
        for (int i = 0; i < 29; i++) send(8'h0A, nb);
        for (int i = 0; i < 80; i++) send(8'h77, nb);
        check("lastcell_addr", 32'(wr_addr), 2399);
        check("lastcell_row", 32'(cursor_row), 0);
        send(8'h52, nb);
        check("wrapclr_cycles", nb, 80);

        // FF after 10 chars, then two ignored codes
        for (int i = 0; i < 10; i++) send(8'h61 + 8'(i), nb);
        send(8'h0C, nb);
        send(8'h07, nb);
        check("ff_clear_cycles", nb, 2400);
        check("ff_count", 32'(char_count), 0);
        send(8'h80, nb);
        check("ff_col", 32'(cursor_col), 0);
        check("ff_row", 32'(cursor_row), 0);

        // Count saturation
        for (int i = 0; i < 4100; i++) send(8'h61 + 8'(i % 26), nb);
        check("count_sat", 32'(char_count), 4095);

        // Reset in the middle of a row clear
        send(8'h0D, nb);
        while (m_row != ROWS - 1) send(8'h0A, nb);
        send(8'h0A, nb);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        check("midrst_wr_en", 32'(wr_en), 0);
        check("midrst_busy", 32'(busy), 1);
        @(negedge clk);
        reset = 1'b0;
        wait_idle(nb);
        check("midrst_clear_cycles", nb, 2400);
        check("midrst_col", 32'(cursor_col), 0);
        check("midrst_row", 32'(cursor_row), 0);
        check("midrst_count", 32'(char_count), 0);

        check("writes_outstanding", exp_addr_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ascii_text_buffer_writer.md
Name: ascii_text_buffer_writer

Overview:
- Consumer end of the ASCII character stream produced by the team's ASCII generator; stream is 8-bit ASCII with a valid/ready handshake.
- Interprets each character as terminal text: places printable characters at a cursor and handles control codes.
- Drives the write port of the character frame buffer (COLS x ROWS) that the text-mode display engine reads.
- Keeps a 12-bit count of written characters so a bench can compare it against the generator's 12-bit generate count.

Parameters:
COLS, 80, characters per row
ROWS, 30, rows per screen
ADDR_W, 12, frame buffer address width; must satisfy COLS*ROWS <= 2**ADDR_W
FILL_CHAR, 8'h20, character written by clear operations

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
ascii_in  input  8  incoming ASCII character
ascii_valid  input  1  ascii_in is valid this cycle
ascii_ready  output  1  block can accept a character this cycle
wr_en  output  1  frame buffer write strobe
wr_addr  output  ADDR_W  frame buffer address, row*COLS+col
wr_data  output  8  frame buffer write data
cursor_col  output  7  current cursor column, 0..COLS-1
cursor_row  output  5  current cursor row, 0..ROWS-1
char_count  output  12  printable characters written since last full clear; saturates at 4095
busy  output  1  a clear operation is in progress

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-high. All outputs are registered.
- Reset values: wr_en=0, wr_addr=0, wr_data=FILL_CHAR, cursor_col=0, cursor_row=0, char_count=0, ascii_ready=0, busy=1. State is CLR_ALL with clear pointer 0.
- Reset asserted mid-operation: any clear or write in progress is abandoned and the block restarts CLR_ALL from address 0.
- Handshake: a character is accepted when ascii_valid && ascii_ready on a rising edge. ascii_ready=1 only in IDLE.
- Latency: the write for an accepted character appears on wr_en/wr_addr/wr_data on the next cycle, as a single-cycle pulse. Back-to-back acceptance is allowed, giving 1 char/cycle sustained when no clear is triggered.
- States:
  - IDLE: ready=1, wr_en=0 except for the registered write of the previous accept.
  - CLR_ALL: ready=0, busy=1. Writes FILL_CHAR to addresses 0..COLS*ROWS-1, one per cycle. Then cursor=(0,0), char_count=0, go to IDLE. Duration is exactly COLS*ROWS cycles.
  - CLR_ROW: ready=0, busy=1. Writes FILL_CHAR to the COLS addresses of cursor_row, then IDLE. Duration is exactly COLS cycles. Cursor_col=0 throughout; char_count is unchanged.
- Character decode on accept:
  - 0x20..0x7E: write the character at (row,col), then col+1 and char_count+1 (saturating).
  - 0x0A (LF): col=0, row+1. No write.
  - 0x0D (CR): col=0. No write.
  - 0x08 (BS): if col>0, col-1 and write FILL_CHAR at the new position; if col=0, no action. char_count is not decremented.
  - 0x0C (FF): enter CLR_ALL. Pointer is 0 and the first fill write occurs on the next cycle.
  - All other codes (0x00..0x1F except the above, 0x7F..0xFF): ignored; cursor unchanged; no write.
- Column wrap: a printable character written at col=COLS-1 sets col=0 and row+1.
- Row overflow: if row+1 equals ROWS, whether from LF or from column wrap, row wraps to 0 and the block enters CLR_ROW for row 0. There is no scrolling. Example: the 2401st printable character of an 80x30 screen lands at (0,0) after row 0 is cleared.
- Simultaneous events: ascii_valid is ignored whenever ready=0; the source must hold the character. An FF accepted in the same cycle that a previous character's write is issued does not suppress that write.
- Address arithmetic: wr_addr = row*COLS + col computed at ADDR_W bits. The multiply uses a constant COLS; no overflow occurs given the parameter rule.

Decomposition:
- Package ascii_text_pkg holds:
  - state enum {CLR_ALL, IDLE, CLR_ROW}
  - control-code constants ASCII_LF, ASCII_CR, ASCII_BS, ASCII_FF, ASCII_PRINT_LO=8'h20, ASCII_PRINT_HI=8'h7E
  - default COLS/ROWS
- One sub-module, text_cursor: holds the col/row registers, applies advance/newline/CR/backspace operations, and flags wrap_row. The top level keeps the FSM, clear pointer, handshake and write port.

Test Plan:
- Reset then idle: after reset deassert, busy=1 for exactly 2400 cycles with wr_en=1 each cycle and addresses 0..2399 of 8'h20; then ready=1, cursor (0,0), char_count=0.
- Print "AB" (0x41, 0x42) back-to-back: writes addr 0=0x41 and addr 1=0x42 on consecutive cycles, each one cycle after its accept; cursor_col=2; char_count=2.
- From col=79, row=0, send 0x5A: write addr 79=0x5A, cursor (0,1). Then LF and CR: cursor (0,2), no wr_en.
- BS at (5,3): write FILL_CHAR at addr 3*80+4=244, cursor_col=4, char_count unchanged. BS at col 0: no write, no change.
- LF at row 29: cursor (0,0), busy=1 for exactly 80 cycles writing addr 0..79; ascii_valid held high meanwhile is not accepted until ready returns.
- Send 0x0C after 10 chars, then 0x07 and 0x80: full 2400-cycle clear, char_count=0, and the two ignored codes produce no write; reset pulsed mid-CLR_ROW restarts CLR_ALL at addr 0.
